// File: rtl/factorial_dispatcher_if.sv
// Request, core and result handshake bundle of the factorial dispatcher.
// The dispatcher takes the slave view; the surrounding environment takes the master view.
interface factorial_dispatcher_if #(
   parameter int IN_DATA_WD  = 4,
   parameter int OUT_DATA_WD = 46
);
   logic [IN_DATA_WD-1:0]  req_data;
   logic                   req_valid;
   logic                   req_ready;
   logic [IN_DATA_WD-1:0]  core_in_data;
   logic                   core_in_valid;
   logic                   core_busy;
   logic [OUT_DATA_WD-1:0] core_out_data;
   logic                   core_out_valid;
   logic [OUT_DATA_WD-1:0] res_data;
   logic [IN_DATA_WD-1:0]  res_arg;
   logic                   res_err;
   logic                   res_valid;
   logic                   res_ready;

   modport slave (
      input  req_data, req_valid, core_busy, core_out_data, core_out_valid, res_ready,
      output req_ready, core_in_data, core_in_valid, res_data, res_arg, res_err, res_valid
   );

   modport master (
      output req_data, req_valid, core_busy, core_out_data, core_out_valid, res_ready,
      input  req_ready, core_in_data, core_in_valid, res_data, res_arg, res_err, res_valid
   );
endinterface

// File: rtl/factorial_dispatcher.sv
// Request FIFO and issue/wait/hold sequencer in front of the factorial core, with a
// per-request timeout and a sticky flag for core results that arrive unsolicited.
module factorial_dispatcher #(
   parameter int IN_DATA_WD  = 4,
   parameter int OUT_DATA_WD = 46,
   parameter int FIFO_DEPTH  = 4,
   parameter int TIMEOUT     = 64
) (
   input  logic                        clk,
   input  logic                        resetn,
   factorial_dispatcher_if.slave       bus,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        stray_err
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int TW = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_HOLD = 2'd2} state_t;

   state_t                 state_r, state_s;
   logic [IN_DATA_WD-1:0]  mem_r [FIFO_DEPTH];
   logic [PW-1:0]          wr_ptr_r, rd_ptr_r;
   logic [CW-1:0]          count_r, count_s;
   logic                   req_ready_r;
   logic                   push_s, pop_s;
   logic [IN_DATA_WD-1:0]  core_in_data_r, core_in_data_s;
   logic                   core_in_valid_r, core_in_valid_s;
   logic [IN_DATA_WD-1:0]  issued_arg_r, issued_arg_s;
   logic [TW-1:0]          timer_r, timer_s;
   logic [OUT_DATA_WD-1:0] res_data_r, res_data_s;
   logic [IN_DATA_WD-1:0]  res_arg_r, res_arg_s;
   logic                   res_err_r, res_err_s;
   logic                   res_valid_r, res_valid_s;
   logic                   stray_err_r, stray_err_s;

   assign push_s = bus.req_valid && req_ready_r;

   // Next-state, issue, result capture and stray-result detection.
   always_comb begin
      state_s         = state_r;
      pop_s           = 1'b0;
      core_in_valid_s = 1'b0;
      core_in_data_s  = core_in_data_r;
      issued_arg_s    = issued_arg_r;
      timer_s         = timer_r;
      res_data_s      = res_data_r;
      res_arg_s       = res_arg_r;
      res_err_s       = res_err_r;
      res_valid_s     = res_valid_r;
      case (state_r)
         ST_IDLE: begin
            if ((count_r != {CW{1'b0}}) && !bus.core_busy) begin
               pop_s           = 1'b1;
               core_in_valid_s = 1'b1;
               core_in_data_s  = mem_r[rd_ptr_r];
               issued_arg_s    = mem_r[rd_ptr_r];
               timer_s         = {TW{1'b0}};
               state_s         = ST_WAIT;
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            // A result arriving on the timeout cycle still counts as a good result.
            if (bus.core_out_valid) begin
               res_data_s  = bus.core_out_data;
               res_arg_s   = issued_arg_r;
               res_err_s   = 1'b0;
               res_valid_s = 1'b1;
               state_s     = ST_HOLD;
            end else if (timer_r == TW'(TIMEOUT - 1)) begin
               res_data_s  = {OUT_DATA_WD{1'b0}};
               res_arg_s   = issued_arg_r;
               res_err_s   = 1'b1;
               res_valid_s = 1'b1;
               state_s     = ST_HOLD;
            end else begin
               timer_s = timer_r + TW'(1);
            end
         end
         ST_HOLD: begin
            if (bus.res_ready) begin
               res_valid_s = 1'b0;
               state_s     = ST_IDLE;
            end else begin
               state_s = ST_HOLD;
            end
         end
         default: state_s = ST_IDLE;
      endcase
      if (bus.core_out_valid && (state_r != ST_WAIT)) begin
         stray_err_s = 1'b1;
      end else begin
         stray_err_s = stray_err_r;
      end
   end

   // FIFO occupancy update; a simultaneous push and pop cancel out.
   always_comb begin
      count_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_s = count_r + CW'(1);
         2'b01:   count_s = count_r - CW'(1);
         default: count_s = count_r;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // FIFO pointers, occupancy and all registered outputs.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_r        <= {PW{1'b0}};
         rd_ptr_r        <= {PW{1'b0}};
         count_r         <= {CW{1'b0}};
         req_ready_r     <= 1'b1;
         core_in_data_r  <= {IN_DATA_WD{1'b0}};
         core_in_valid_r <= 1'b0;
         issued_arg_r    <= {IN_DATA_WD{1'b0}};
         timer_r         <= {TW{1'b0}};
         res_data_r      <= {OUT_DATA_WD{1'b0}};
         res_arg_r       <= {IN_DATA_WD{1'b0}};
         res_err_r       <= 1'b0;
         res_valid_r     <= 1'b0;
         stray_err_r     <= 1'b0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
         count_r         <= count_s;
         req_ready_r     <= (count_s < CW'(FIFO_DEPTH));
         core_in_data_r  <= core_in_data_s;
         core_in_valid_r <= core_in_valid_s;
         issued_arg_r    <= issued_arg_s;
         timer_r         <= timer_s;
         res_data_r      <= res_data_s;
         res_arg_r       <= res_arg_s;
         res_err_r       <= res_err_s;
         res_valid_r     <= res_valid_s;
         stray_err_r     <= stray_err_s;
      end
   end

   // Request storage; an entry is only read after it has been written.
   always_ff @(posedge clk) begin
      if (push_s) mem_r[wr_ptr_r] <= bus.req_data;
   end

   assign bus.req_ready     = req_ready_r;
   assign bus.core_in_data  = core_in_data_r;
   assign bus.core_in_valid = core_in_valid_r;
   assign bus.res_data      = res_data_r;
   assign bus.res_arg       = res_arg_r;
   assign bus.res_err       = res_err_r;
   assign bus.res_valid     = res_valid_r;
   assign fifo_count        = count_r;
   assign stray_err         = stray_err_r;
endmodule

// File: tb/tb_factorial_dispatcher.sv
// Bench for factorial_dispatcher: a behavioural factorial core with random latency, and a
// scoreboard expecting every accepted request to come back in order as n! (or a timeout).
module tb_factorial_dispatcher;
   localparam int IW = 4;
   localparam int OW = 46;
   localparam int DEPTH = 4;
   localparam int TMO = 64;

   typedef struct { logic [IW-1:0] arg; logic [OW-1:0] data; logic err; } exp_t;

   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic [$clog2(DEPTH):0] fifo_count;
   logic stray_err;

   factorial_dispatcher_if #(.IN_DATA_WD(IW), .OUT_DATA_WD(OW)) bus ();

   factorial_dispatcher #(
      .IN_DATA_WD(IW), .OUT_DATA_WD(OW), .FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus), .fifo_count(fifo_count), .stray_err(stray_err)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int t0;
   exp_t exp_q[$];
   logic [IW-1:0] req_q[$];
   logic [IW-1:0] iss_q[$];
   logic civ_prev = 1'b0;
   logic core_hang = 1'b0;
   logic force_busy = 1'b0;
   int stray_cnt = 0;
   int stray_seen;

   logic busy_m;
   logic [IW-1:0] arg_m;
   int lat_m;
   logic ov_m;
   logic [OW-1:0] od_m;

   assign bus.core_busy      = busy_m | force_busy;
   assign bus.core_out_valid = ov_m;
   assign bus.core_out_data  = od_m;

   function automatic logic [OW-1:0] fact(input logic [IW-1:0] n);
      longint p = 1;
      for (int i = 2; i <= int'(n); i++) p = p * longint'(i);
      return OW'(p);
   endfunction

   // Behavioural core: latches the argument on the issue pulse, stays busy for a random
   // number of cycles, then strobes n!. In hang mode it accepts the argument but never answers.
   always @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_m     <= 1'b0;
         ov_m       <= 1'b0;
         od_m       <= '0;
         arg_m      <= '0;
         lat_m      <= 0;
         stray_seen <= stray_cnt;
      end else begin
         ov_m <= 1'b0;
         if (stray_seen != stray_cnt) begin
            stray_seen <= stray_cnt;
            ov_m       <= 1'b1;
            od_m       <= 46'h2A;
         end else if (bus.core_in_valid) begin
            arg_m  <= bus.core_in_data;
            busy_m <= !core_hang;
            lat_m  <= int'($urandom_range(0, 5));
         end else if (busy_m) begin
            if (lat_m == 0) begin
               ov_m   <= 1'b1;
               od_m   <= fact(arg_m);
               busy_m <= 1'b0;
            end else begin
               lat_m <= lat_m - 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scores the handshakes completing at the coming edge, advances one cycle, checks any
   // issue pulse, then presents the next queued request.
   task automatic tick();
      exp_t e;
      if (bus.res_valid && bus.res_ready) begin
         if (exp_q.size() == 0) begin
            check("res_unexpected", bus.res_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("res_data", bus.res_data, e.data);
            check("res_arg", bus.res_arg, e.arg);
            check("res_err", bus.res_err, e.err);
         end
      end
      if (bus.req_valid && bus.req_ready) begin
         e.arg  = req_q[0];
         e.err  = core_hang;
         e.data = core_hang ? '0 : fact(req_q[0]);
         exp_q.push_back(e);
         iss_q.push_back(req_q[0]);
         void'(req_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      if (bus.core_in_valid) begin
         if (iss_q.size() == 0) check("issue_unexpected", bus.core_in_valid, 1'b0);
         else check("issue_arg", bus.core_in_data, iss_q.pop_front());
         check("issue_pulse_width", civ_prev, 1'b0);
      end
      civ_prev = bus.core_in_valid;
      bus.req_valid = (req_q.size() != 0);
      bus.req_data  = (req_q.size() != 0) ? req_q[0] : '0;
   endtask

   task automatic drain(input string tag, input int budget);
      for (int k = 0; k < budget && (exp_q.size() != 0 || req_q.size() != 0); k++) tick();
      check(tag, exp_q.size() + req_q.size(), 0);
   endtask

   task automatic check_reset(input string pfx);
      check({pfx, "_req_ready"}, bus.req_ready, 1'b1);
      check({pfx, "_core_in_valid"}, bus.core_in_valid, 1'b0);
      check({pfx, "_core_in_data"}, bus.core_in_data, 0);
      check({pfx, "_res_valid"}, bus.res_valid, 1'b0);
      check({pfx, "_res_data"}, bus.res_data, 0);
      check({pfx, "_res_arg"}, bus.res_arg, 0);
      check({pfx, "_res_err"}, bus.res_err, 1'b0);
      check({pfx, "_fifo_count"}, fifo_count, 0);
      check({pfx, "_stray_err"}, stray_err, 1'b0);
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_data  = '0;
      bus.res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset("rst");
      resetn = 1'b1;
      tick();

      // T1: single request on an idle DUT
      req_q.push_back(4'd5);
      tick();
      tick();
      check("t1_count_after_push", fifo_count, 1);
      check("t1_no_issue_on_push_edge", bus.core_in_valid, 1'b0);
      tick();
      check("t1_issue_pulse", bus.core_in_valid, 1'b1);
      check("t1_issue_data", bus.core_in_data, 4'd5);
      for (int k = 0; k < 20 && !bus.res_valid; k++) tick();
      check("t1_res_valid", bus.res_valid, 1'b1);
      check("t1_res_data", bus.res_data, 120);
      check("t1_res_arg", bus.res_arg, 4'd5);
      check("t1_res_err", bus.res_err, 1'b0);
      drain("t1_drain", 50);

      // T2: fill the FIFO behind a busy core, then release it
      force_busy = 1'b1;
      req_q.push_back(4'd3);
      req_q.push_back(4'd4);
      req_q.push_back(4'd6);
      req_q.push_back(4'd0);
      req_q.push_back(4'd7);
      repeat (8) tick();
      check("t2_full_count", fifo_count, DEPTH);
      check("t2_full_ready", bus.req_ready, 1'b0);
      check("t2_fifth_held_back", req_q.size(), 1);
      force_busy = 1'b0;
      drain("t2_drain", 200);

      // T3: back-pressure on the result port
      bus.res_ready = 1'b0;
      req_q.push_back(4'd2);
      req_q.push_back(4'd7);
      req_q.push_back(4'd9);
      for (int k = 0; k < 40 && !bus.res_valid; k++) tick();
      for (int k = 0; k < 10; k++) begin
         check("t3_hold_valid", bus.res_valid, 1'b1);
         check("t3_hold_data", bus.res_data, exp_q[0].data);
         check("t3_hold_arg", bus.res_arg, exp_q[0].arg);
         check("t3_hold_no_issue", bus.core_in_valid, 1'b0);
         check("t3_hold_queued", fifo_count, 2);
         tick();
      end
      bus.res_ready = 1'b1;
      drain("t3_drain", 200);

      // T4: hung core, timeout, then normal operation again
      core_hang = 1'b1;
      req_q.push_back(4'd9);
      for (int k = 0; k < 10 && !bus.core_in_valid; k++) tick();
      check("t4_issue", bus.core_in_valid, 1'b1);
      t0 = cyc;
      for (int k = 0; k < 100 && !bus.res_valid; k++) tick();
      check("t4_timeout_latency", cyc - t0, TMO);
      check("t4_timeout_err", bus.res_err, 1'b1);
      check("t4_timeout_data", bus.res_data, 0);
      drain("t4_drain_timeout", 10);
      core_hang = 1'b0;
      req_q.push_back(4'd11);
      for (int k = 0; k < 10 && !bus.core_in_valid; k++) tick();
      check("t4_next_issue", bus.core_in_valid, 1'b1);
      drain("t4_drain_next", 50);

      // T5: issue blocked by core_busy, then a spurious core result while idle
      force_busy = 1'b1;
      req_q.push_back(4'd12);
      req_q.push_back(4'd13);
      for (int k = 0; k < 8; k++) begin
         tick();
         check("t5_no_issue_while_busy", bus.core_in_valid, 1'b0);
      end
      check("t5_queued", fifo_count, 2);
      force_busy = 1'b0;
      tick();
      check("t5_issue_after_busy", bus.core_in_valid, 1'b1);
      check("t5_issue_data", bus.core_in_data, 4'd12);
      drain("t5_drain", 100);
      check("t5_stray_clear", stray_err, 1'b0);
      stray_cnt++;
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t5_no_result_from_stray", bus.res_valid, 1'b0);
      end
      check("t5_stray_set", stray_err, 1'b1);

      // Random traffic with random result back-pressure
      for (int k = 0; k < 400; k++) begin
         if (req_q.size() < 2 && $urandom_range(0, 2) == 0) req_q.push_back(IW'($urandom_range(0, 15)));
         bus.res_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      bus.res_ready = 1'b1;
      drain("rand_drain", 400);
      check("rand_stray_sticky", stray_err, 1'b1);

      // T6: asynchronous reset while waiting with three requests queued
      core_hang = 1'b1;
      req_q.push_back(4'd1);
      req_q.push_back(4'd2);
      req_q.push_back(4'd3);
      req_q.push_back(4'd4);
      repeat (8) tick();
      check("t6_queued", fifo_count, 3);
      #2;
      resetn = 1'b0;
      #1;
      check_reset("t6_async");
      req_q.delete();
      exp_q.delete();
      iss_q.delete();
      bus.req_valid = 1'b0;
      core_hang = 1'b0;
      civ_prev = 1'b0;
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("t6_no_stale_result", bus.res_valid, 1'b0);
      end
      check("t6_count_after_reset", fifo_count, 0);
      check("t6_stray_after_reset", stray_err, 1'b0);
      req_q.push_back(4'd4);
      drain("t6_drain_after_reset", 50);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
